// File: rtl/tone_pkg.sv
// Shared types and constants for the Simon speaker scheduler: state encoding,
// grant bit positions, note-code type and the fixed 4-note jingle tables.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAMP   = 2'd1,
    ST_JINGLE = 2'd2
  } state_e;

  localparam int G_LAMP = 0;
  localparam int G_HS   = 1;
  localparam int G_WIN  = 2;
  localparam int G_LOSE = 3;

  typedef logic [2:0] note_t;
  typedef logic [3:0][2:0] rom_t;

  // Element [0] is the first note played.
  localparam rom_t ROM_LOSE = {3'd0, 3'd0, 3'd1, 3'd1};
  localparam rom_t ROM_WIN  = {3'd7, 3'd6, 3'd5, 3'd4};
  localparam rom_t ROM_HS   = {3'd5, 3'd7, 3'd5, 3'd7};

  function automatic note_t lamp_note(input logic [1:0] lamp);
    return {lamp, 1'b0};
  endfunction

  function automatic note_t jingle_note(input logic [3:0] grant, input logic [1:0] idx);
    if (grant[G_LOSE])     return ROM_LOSE[idx];
    else if (grant[G_WIN]) return ROM_WIN[idx];
    else if (grant[G_HS])  return ROM_HS[idx];
    else                   return 3'd0;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: half-period counter plus speaker flop. Restart or a
// disabled generator clears both, so every tone starts low from count zero.
module tone_gen
  import tone_pkg::*;
#(
  parameter int BASE_HALF = 12500,
  parameter int DIV_W     = 17
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  note_t code,
  input  logic  restart,
  input  logic  enable,
  output logic  spk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d, half_m1;
  logic             spk_q, spk_d;

  always_comb begin
    half_m1 = DIV_W'(BASE_HALF * (8 - int'(code)) - 1);
    cnt_d   = cnt_q;
    spk_d   = spk_q;
    if (restart || !enable) begin
      cnt_d = '0;
      spk_d = 1'b0;
    end else if (cnt_q == half_m1) begin
      cnt_d = '0;
      spk_d = ~spk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  assign spk_o = spk_q;

endmodule

// File: rtl/tone_sched.sv
// Speaker scheduler: arbitrates lamp tone and LOSE/WIN/HS jingles onto one tone
// generator. Optional `TONE_MUTE_EN adds a MUTE input that gates SPK low.
module tone_sched
  import tone_pkg::*;
#(
  parameter int BASE_HALF = 12500,
  parameter int NOTE_CYC  = 5_000_000,
  parameter int DIV_W     = 17,
  parameter int DUR_W     = 23
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       HS_REQ,
  input  logic       WIN_REQ,
  input  logic       LOSE_REQ,
`ifdef TONE_MUTE_EN
  input  logic       MUTE,
`endif
  output logic       SPK,
  output logic [3:0] GRANT,
  output logic       BUSY
);

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       idx_q, idx_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0]       lamp_q;
  logic [3:0]       req, jsel;
  logic             pick, note_start, lamp_chg, restart, gen_spk;
  note_t            code;

  assign req = {LOSE_REQ, WIN_REQ, HS_REQ, 1'b0};

  always_comb begin
    jsel = 4'b0000;
    if (pend_q[G_LOSE])     jsel[G_LOSE] = 1'b1;
    else if (pend_q[G_WIN]) jsel[G_WIN]  = 1'b1;
    else if (pend_q[G_HS])  jsel[G_HS]   = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    pend_d     = pend_q | req;
    idx_d      = idx_q;
    dur_d      = dur_q;
    note_start = 1'b0;
    pick       = 1'b0;

    case (state_q)
      ST_IDLE, ST_LAMP: pick = 1'b1;
      ST_JINGLE: begin
        if (dur_q == DUR_W'(NOTE_CYC - 1)) begin
          if (idx_q == 2'd3) begin
            pick = 1'b1;
          end else begin
            idx_d      = idx_q + 2'd1;
            dur_d      = '0;
            note_start = 1'b1;
          end
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      default: pick = 1'b1;
    endcase

    // A request arriving on the grant edge re-arms the bit for one replay.
    if (pick) begin
      if (|pend_q) begin
        state_d    = ST_JINGLE;
        grant_d    = jsel;
        pend_d     = (pend_q & ~jsel) | req;
        idx_d      = 2'd0;
        dur_d      = '0;
        note_start = 1'b1;
      end else if (LAMP_ENA) begin
        state_d = ST_LAMP;
        grant_d = 4'b0001;
      end else begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    end
  end

  assign lamp_chg = (state_q == ST_LAMP) && (state_d == ST_LAMP) && (LAMP != lamp_q);
  assign restart  = note_start || lamp_chg || (grant_d != grant_q);
  assign code     = (state_q == ST_LAMP) ? lamp_note(lamp_q) : jingle_note(grant_q, idx_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      pend_q  <= 4'b0000;
      idx_q   <= 2'd0;
      dur_q   <= '0;
      lamp_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      lamp_q  <= LAMP;
    end
  end

  tone_gen #(
    .BASE_HALF(BASE_HALF),
    .DIV_W    (DIV_W)
  ) u_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .code   (code),
    .restart(restart),
    .enable (state_q != ST_IDLE),
    .spk_o  (gen_spk)
  );

  assign GRANT = grant_q;
  assign BUSY  = (state_q == ST_JINGLE) || (|pend_q);

`ifdef TONE_MUTE_EN
  assign SPK = gen_spk & ~MUTE;
`else
  assign SPK = gen_spk;
`endif

endmodule
